id_ex_skid: RTL

//  Parametrised decode->execute pipeline register for the Y86 core: next generation of the plain ID/EX latch.

---
 rtl/id_ex_skid.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_skid.sv
// ---------------------------------------------------------------------------
// id_ex_skid
//   Decode -> execute pipeline register for the Y86 core. A ready/valid
//   handshake on both sides, a main entry that drives ex_* directly and a
//   skid entry that absorbs the one instruction decode may send in the same
//   cycle that execute stalls. id_ready depends only on registered state, so
//   there is no combinational path from ex_ready back to decode.
//   While no real instruction is held, the control fields read as a nop with
//   no destination registers, so a consumer ignoring ex_valid stays safe.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   flush             synchronous squash of everything held (wins over all)
//   id_valid/id_ready decode-side handshake
//   id_icode..id_dstM decode control fields (BYTE_W)
//   id_valA..id_valP  decode data values (WORD_W)
//   ex_valid/ex_ready execute-side handshake
//   ex_icode..ex_dstM registered control fields (bubble values when idle)
//   ex_valA..ex_valP  registered data values (hold last value when idle)
//   occupancy         entries held: 0, 1 or 2
//   bubble_cnt        saturating count of cycles with ex_ready=1, ex_valid=0
// ---------------------------------------------------------------------------
module id_ex_skid #(
  parameter int                 WORD_W    = 32,
  parameter int                 BYTE_W    = 8,
  parameter logic [BYTE_W-1:0]  NOP_ICODE = 'h01,
  parameter logic [BYTE_W-1:0]  RNONE     = 'h0F,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [BYTE_W-1:0] id_icode,
  input  logic [BYTE_W-1:0] id_ifun,
  input  logic [BYTE_W-1:0] id_dstE,
  input  logic [BYTE_W-1:0] id_dstM,
  input  logic [WORD_W-1:0] id_valA,
  input  logic [WORD_W-1:0] id_valB,
  input  logic [WORD_W-1:0] id_valC,
  input  logic [WORD_W-1:0] id_valP,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [BYTE_W-1:0] ex_icode,
  output logic [BYTE_W-1:0] ex_ifun,
  output logic [BYTE_W-1:0] ex_dstE,
  output logic [BYTE_W-1:0] ex_dstM,
  output logic [WORD_W-1:0] ex_valA,
  output logic [WORD_W-1:0] ex_valB,
  output logic [WORD_W-1:0] ex_valC,
  output logic [WORD_W-1:0] ex_valP,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic accept, pop;
  logic ld_main_id, ld_main_skid, ld_skid, to_bubble;

  logic [BYTE_W-1:0] skid_icode, skid_ifun, skid_dstE, skid_dstM;
  logic [WORD_W-1:0] skid_valA, skid_valB, skid_valC, skid_valP;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Handshake derived purely from the state register.
  assign id_ready  = (state != FULL);
  assign ex_valid  = (state != EMPTY);
  assign occupancy = state;
  assign accept    = id_valid & id_ready;
  assign pop       = ex_valid & ex_ready;

  always_comb begin
    state_nxt    = state;
    ld_main_id   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    to_bubble    = 1'b0;
    if (flush) begin
      // Same-cycle accept is intentionally dropped.
      state_nxt = EMPTY;
      to_bubble = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            ld_main_id = 1'b1;
            state_nxt  = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            ld_main_id = 1'b1;
          end else if (accept) begin
            ld_skid   = 1'b1;
            state_nxt = FULL;
          end else if (pop) begin
            to_bubble = 1'b1;
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            ld_main_skid = 1'b1;
            state_nxt    = ONE;
          end
        end
        default: begin
          to_bubble = 1'b1;
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Main entry: bubble fields on emptying, values keep their last contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_icode <= NOP_ICODE;
      ex_ifun  <= '0;
      ex_dstE  <= RNONE;
      ex_dstM  <= RNONE;
      ex_valA  <= '0;
      ex_valB  <= '0;
      ex_valC  <= '0;
      ex_valP  <= '0;
    end else if (to_bubble) begin
      ex_icode <= NOP_ICODE;
      ex_ifun  <= '0;
      ex_dstE  <= RNONE;
      ex_dstM  <= RNONE;
    end else if (ld_main_id) begin
      ex_icode <= id_icode;
      ex_ifun  <= id_ifun;
      ex_dstE  <= id_dstE;
      ex_dstM  <= id_dstM;
      ex_valA  <= id_valA;
      ex_valB  <= id_valB;
      ex_valC  <= id_valC;
      ex_valP  <= id_valP;
    end else if (ld_main_skid) begin
      ex_icode <= skid_icode;
      ex_ifun  <= skid_ifun;
      ex_dstE  <= skid_dstE;
      ex_dstM  <= skid_dstM;
      ex_valA  <= skid_valA;
      ex_valB  <= skid_valB;
      ex_valC  <= skid_valC;
      ex_valP  <= skid_valP;
    end
  end

  // Skid entry: contents only meaningful in FULL, so no reset needed.
  always_ff @(posedge clk) begin
    if (ld_skid) begin
      skid_icode <= id_icode;
      skid_ifun  <= id_ifun;
      skid_dstE  <= id_dstE;
      skid_dstM  <= id_dstM;
      skid_valA  <= id_valA;
      skid_valB  <= id_valB;
      skid_valC  <= id_valC;
      skid_valP  <= id_valP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     bubble_cnt <= '0;
    else if (ex_ready && !ex_valid) bubble_cnt <= sat_inc(bubble_cnt);
  end

endmodule
